// File: rtl/afifo_wr_packer_pkg.sv
// Shared constants for the dual-clock FIFO packer/unpacker pair.
// Default lane geometry and the word-counter width used on both FIFO sides.
package afifo_wr_packer_pkg;

  localparam int DEF_IN_WIDTH = 2;
  localparam int DEF_RATIO    = 4;
  localparam int DEF_WIDTH    = DEF_IN_WIDTH * DEF_RATIO;
  localparam int DEF_LANE_W   = $clog2(DEF_RATIO);

  // Word counter width, shared with the read-side unpacker.
  localparam int WR_CNT_W = 16;

endpackage

// File: rtl/afifo_wr_packer.sv
// Write-side producer for the dual-clock FIFO: packs RATIO narrow beats LSB-first
// into one FIFO word, flushing partial words on s_last, with a one-entry output stage.
module afifo_wr_packer
  import afifo_wr_packer_pkg::*;
#(
  parameter int IN_WIDTH = DEF_IN_WIDTH,
  parameter int RATIO    = DEF_RATIO
) (
  input  logic                         wclk,
  input  logic                         wrstn,
  input  logic                         s_valid,
  input  logic [IN_WIDTH-1:0]          s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic                         winc,
  output logic [IN_WIDTH*RATIO-1:0]    wdata,
  input  logic                         wfull,
  output logic                         busy,
  output logic [WR_CNT_W-1:0]          wr_cnt
);

  localparam int WIDTH  = IN_WIDTH * RATIO;
  localparam int LANE_W = $clog2(RATIO);

  logic [WIDTH-1:0]    pack_q, pack_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic                outValid_q, outValid_d;
  logic [WIDTH-1:0]    wdata_q, wdata_d;
  logic [WR_CNT_W-1:0] wrCnt_q, wrCnt_d;

  logic             accept;
  logic             complete;
  logic [WIDTH-1:0] beatShifted;
  logic [WIDTH-1:0] mergedWord;

  assign s_ready  = !outValid_q || !wfull;
  assign winc     = outValid_q && !wfull;
  assign accept   = s_valid && s_ready;
  assign complete = accept && ((lane_q == LANE_W'(RATIO - 1)) || s_last);

  // Lanes above the current one are still zero, so OR-ing in the beat zero-pads them.
  assign beatShifted = WIDTH'(s_data) << (int'(lane_q) * IN_WIDTH);
  assign mergedWord  = pack_q | beatShifted;

  always_comb begin
    pack_d     = pack_q;
    lane_d     = lane_q;
    outValid_d = outValid_q;
    wdata_d    = wdata_q;
    wrCnt_d    = wrCnt_q;

    if (winc) begin
      outValid_d = 1'b0;
      wrCnt_d    = wrCnt_q + WR_CNT_W'(1);
    end

    // A completing accept after a write reloads the output stage with no bubble.
    if (complete) begin
      wdata_d    = mergedWord;
      outValid_d = 1'b1;
      pack_d     = '0;
      lane_d     = '0;
    end else if (accept) begin
      pack_d = mergedWord;
      lane_d = lane_q + LANE_W'(1);
    end
  end

  always_ff @(posedge wclk or negedge wrstn) begin
    if (!wrstn) begin
      pack_q     <= '0;
      lane_q     <= '0;
      outValid_q <= 1'b0;
      wdata_q    <= '0;
      wrCnt_q    <= '0;
    end else begin
      pack_q     <= pack_d;
      lane_q     <= lane_d;
      outValid_q <= outValid_d;
      wdata_q    <= wdata_d;
      wrCnt_q    <= wrCnt_d;
    end
  end

  assign wdata  = wdata_q;
  assign wr_cnt = wrCnt_q;
  assign busy   = outValid_q || (lane_q != '0);

endmodule

// File: tb/tb_afifo_wr_packer.sv
// Self-checking bench for afifo_wr_packer: directed cases plus random traffic
// checked against a beat-list / word-queue reference model.
module tb_afifo_wr_packer;

  localparam int IN_WIDTH = 2;
  localparam int RATIO    = 4;
  localparam int WIDTH    = IN_WIDTH * RATIO;

  logic                wclk;
  logic                wrstn;
  logic                s_valid;
  logic [IN_WIDTH-1:0] s_data;
  logic                s_last;
  logic                s_ready;
  logic                winc;
  logic [WIDTH-1:0]    wdata;
  logic                wfull;
  logic                busy;
  logic [15:0]         wr_cnt;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: beats of the word being gathered, words completed but not yet written.
  int          curBeats[$];
  int          pendWords[$];
  logic [15:0] modelCnt;

  afifo_wr_packer #(.IN_WIDTH(IN_WIDTH), .RATIO(RATIO)) dut (
    .wclk    (wclk),
    .wrstn   (wrstn),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .winc    (winc),
    .wdata   (wdata),
    .wfull   (wfull),
    .busy    (busy),
    .wr_cnt  (wr_cnt)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic int wordFromBeats(input int beats[$]);
    int word = 0;
    int scale = 1;
    foreach (beats[i]) begin
      word += beats[i] * scale;
      scale *= (1 << IN_WIDTH);
    end
    return word;
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic applyStimulus(input logic v, input logic [IN_WIDTH-1:0] d, input logic l, input logic f);
    logic expReady;
    logic expWinc;
    s_valid = v;
    s_data  = d;
    s_last  = l;
    wfull   = f;
    @(negedge wclk);
    expReady = (pendWords.size() == 0) || !f;
    expWinc  = (pendWords.size() != 0) && !f;
    checkOutput("s_ready", 32'(s_ready), 32'(expReady));
    checkOutput("winc", 32'(winc), 32'(expWinc));
    checkOutput("busy", 32'(busy), 32'((pendWords.size() != 0) || (curBeats.size() != 0)));
    checkOutput("wr_cnt", 32'(wr_cnt), 32'(modelCnt));
    if (pendWords.size() != 0)
      checkOutput("wdata", 32'(wdata), 32'(pendWords[0]));
    if (expWinc) begin
      void'(pendWords.pop_front());
      modelCnt = modelCnt + 16'd1;
    end
    if (v && expReady) begin
      curBeats.push_back(int'(d));
      if (curBeats.size() == RATIO || l) begin
        pendWords.push_back(wordFromBeats(curBeats));
        curBeats.delete();
      end
    end
    @(posedge wclk);
    #1;
  endtask

  // Pulse reset for one cycle with a beat offered; nothing may be captured.
  task automatic doReset();
    wrstn   = 1'b0;
    s_valid = 1'b1;
    s_data  = 2'b11;
    s_last  = 1'b0;
    wfull   = 1'b0;
    #1;
    checkOutput("rst_s_ready", 32'(s_ready), 32'd1);
    checkOutput("rst_winc", 32'(winc), 32'd0);
    checkOutput("rst_wdata", 32'(wdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    @(posedge wclk);
    #1;
    checkOutput("rst_hold_busy", 32'(busy), 32'd0);
    wrstn = 1'b1;
    curBeats.delete();
    pendWords.delete();
    modelCnt = '0;
  endtask

  initial begin
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    wfull    = 1'b0;
    wrstn    = 1'b1;
    modelCnt = '0;
    @(posedge wclk);
    #1;
    doReset();

    // Full word 01,10,11,00 -> 0x39
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    s_valid = 1'b0;
    #1;
    checkOutput("full_word_winc", 32'(winc), 32'd1);
    checkOutput("full_word_data", 32'(wdata), 32'h39);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("full_word_cnt", 32'(wr_cnt), 32'd1);

    // Short burst 11, 01+last -> 0x07, then 11 x4 -> 0xFF
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
    checkOutput("short_data", 32'(wdata), 32'h07);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("ff_data", 32'(wdata), 32'hFF);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Backpressure: pending word held for 5 full cycles while beats are offered
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
    checkOutput("bp_data", 32'(wdata), 32'hE4);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Streaming: 16 back-to-back beats
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("stream_cnt", 32'(wr_cnt), 32'(modelCnt));

    // Reset mid-pack, then 10 x4 -> 0xAA
    applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
    checkOutput("after_rst_data", 32'(wdata), 32'hAA);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // s_last on the final lane yields exactly one word
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
    applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
    checkOutput("last_on_top_data", 32'(wdata), 32'hD5);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Random traffic with backpressure and bursts
    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 3));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);

    // Counter wrap: 65537 single-lane words
    doReset();
    for (int i = 0; i < 65537; i++) applyStimulus(1'b1, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("wrap_cnt", 32'(wr_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
